// File: rtl/voice_allocator_if.sv
// Event handshake and per-voice output bundle between an upstream note source
// (master) and the voice allocator (slave).
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_WIDTH = 7,
  parameter int FREQ_WIDTH = 8
);
  // Handshake: an event transfers on a rising edge where EventValid and
  // EventReady are both 1; the master holds EventValid and all Event* data
  // stable until that edge, and Ready never depends combinationally on Valid.
  logic                             EventValid;
  logic                             EventReady;
  logic                             EventOn;
  logic [NOTE_WIDTH-1:0]            EventNote;
  logic [FREQ_WIDTH-1:0]            EventFreq;
  logic [NUM_VOICES*FREQ_WIDTH-1:0] VoiceFreq;
  logic [NUM_VOICES-1:0]            Gate;
  logic [NUM_VOICES-1:0]            Retrigger;
  logic                             Stolen;
  logic                             Busy;

  modport master (
    output EventValid, EventOn, EventNote, EventFreq,
    input  EventReady, VoiceFreq, Gate, Retrigger, Stolen, Busy
  );

  modport slave (
    input  EventValid, EventOn, EventNote, EventFreq,
    output EventReady, VoiceFreq, Gate, Retrigger, Stolen, Busy
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans one voice per cycle, then commits a
// note-on (retrigger / free / steal oldest) or a note-off to the voice table.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_WIDTH = 7,
  parameter int FREQ_WIDTH = 8,
  parameter int AGE_WIDTH  = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  voice_allocator_if.slave       bus,
  output logic [1:0]             dbg_state
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e                                 state_q, state_d;
  logic [IDX_W-1:0]                       scan_idx_q, scan_idx_d;
  logic                                   ev_on_q, ev_on_d;
  logic [NOTE_WIDTH-1:0]                  ev_note_q, ev_note_d;
  logic [FREQ_WIDTH-1:0]                  ev_freq_q, ev_freq_d;
  logic                                   match_found_q, match_found_d;
  logic [IDX_W-1:0]                       match_idx_q, match_idx_d;
  logic                                   free_found_q, free_found_d;
  logic [IDX_W-1:0]                       free_idx_q, free_idx_d;
  logic                                   old_found_q, old_found_d;
  logic [IDX_W-1:0]                       old_idx_q, old_idx_d;
  logic [AGE_WIDTH-1:0]                   old_age_q, old_age_d;
  logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0]  note_q, note_d;
  logic [NUM_VOICES-1:0][FREQ_WIDTH-1:0]  freq_q, freq_d;
  logic [NUM_VOICES-1:0][AGE_WIDTH-1:0]   age_q, age_d;
  logic [NUM_VOICES-1:0]                  gate_q, gate_d;
  logic [NUM_VOICES-1:0]                  retrig_q, retrig_d;
  logic                                   stolen_q, stolen_d;
  logic [IDX_W-1:0]                       tgt;
  logic                                   steal;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_freq_q     <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      note_q        <= '0;
      freq_q        <= '0;
      age_q         <= '0;
      gate_q        <= '0;
      retrig_q      <= '0;
      stolen_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      ev_freq_q     <= ev_freq_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      note_q        <= note_d;
      freq_q        <= freq_d;
      age_q         <= age_d;
      gate_q        <= gate_d;
      retrig_q      <= retrig_d;
      stolen_q      <= stolen_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    ev_freq_d     = ev_freq_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    note_d        = note_q;
    freq_d        = freq_q;
    age_d         = age_q;
    gate_d        = gate_q;
    retrig_d      = '0;
    stolen_d      = 1'b0;
    tgt           = old_idx_q;
    steal         = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.EventValid) begin
          ev_on_d       = bus.EventOn;
          ev_note_d     = bus.EventNote;
          ev_freq_d     = bus.EventFreq;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          match_idx_d   = '0;
          free_idx_d    = '0;
          old_idx_d     = '0;
          old_age_d     = '0;
          scan_idx_d    = '0;
          state_d       = SCAN;
        end
      end

      SCAN: begin
        if (gate_q[scan_idx_q] && note_q[scan_idx_q] == ev_note_q && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
        if (!gate_q[scan_idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        // Strict '>' keeps the lowest index on equal ages.
        if (gate_q[scan_idx_q] && (!old_found_q || age_q[scan_idx_q] > old_age_q)) begin
          old_found_d = 1'b1;
          old_idx_d   = scan_idx_q;
          old_age_d   = age_q[scan_idx_q];
        end
        if (scan_idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (ev_on_q) begin
          if (match_found_q) begin
            tgt   = match_idx_q;
            steal = 1'b0;
          end else if (free_found_q) begin
            tgt   = free_idx_q;
            steal = 1'b0;
          end
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (gate_q[v] && age_q[v] != '1) begin
              age_d[v] = age_q[v] + AGE_WIDTH'(1);
            end
          end
          note_d[tgt]   = ev_note_q;
          freq_d[tgt]   = ev_freq_q;
          gate_d[tgt]   = 1'b1;
          age_d[tgt]    = '0;
          retrig_d[tgt] = 1'b1;
          stolen_d      = steal;
        end else if (match_found_q) begin
          // Release only: note and freq stay so the envelope tail plays out.
          gate_d[match_idx_q] = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.EventReady = (state_q == IDLE);
  assign bus.Busy       = (state_q != IDLE);
  assign bus.VoiceFreq  = freq_q;
  assign bus.Gate       = gate_q;
  assign bus.Retrigger  = retrig_q;
  assign bus.Stolen     = stolen_q;
  assign dbg_state      = state_q;
endmodule
